// File: rtl/vpe_pkg.sv
// vpe_pkg: shared VPE types and PSUM saturation bounds
// Holds the accumulator FSM state type and the signed PSUM limits reused by
// the dequantiser clip.
package vpe_pkg;
  typedef enum logic {IDLE, ACCUM} vpe_accum_state_t;
  localparam int PSUM_W = 32;
  localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
endpackage

// File: rtl/vpe_sat_adder.sv
// vpe_sat_adder: signed adder, saturating when VPE_ACCUM_SAT_EN is defined
// Ports: a, b (signed operands) -> sum (signed result), ovf (saturation event)
// Without VPE_ACCUM_SAT_EN the sum wraps and ovf is tied low.
module vpe_sat_adder #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);
  logic signed [WIDTH-1:0] raw;
  assign raw = a + b;
`ifdef VPE_ACCUM_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflow only when both operands share a sign the result does not.
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
  assign sum = ovf ? (a[WIDTH-1] ? MIN : MAX) : raw;
`else
  assign ovf = 1'b0;
  assign sum = raw;
`endif
endmodule

// File: rtl/vpe_psum_accum.sv
// vpe_psum_accum: K-tile partial-sum accumulator feeding the lane dequantiser
// Ports: clk, rst (sync, active-low); accum_start/num_k_tiles/tile_rows start
// a tile; accum_in_valid/accum_in carry partial sums; accum_out_valid/accum_out
// stream final sums one cycle after the final-pass input; accum_busy,
// accum_done, accum_overflow report status.
// Macro VPE_ACCUM_SAT_EN selects saturating (vs wrapping) accumulation.
module vpe_psum_accum
  import vpe_pkg::*;
#(
  parameter int PSUM_WIDTH  = PSUM_W,
  parameter int DEPTH       = 16,
  parameter int KTILE_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accum_start,
  input  logic [KTILE_WIDTH-1:0]       num_k_tiles,
  input  logic [$clog2(DEPTH+1)-1:0]   tile_rows,
  input  logic                         accum_in_valid,
  input  logic [PSUM_WIDTH-1:0]        accum_in,
  output logic                         accum_out_valid,
  output logic [PSUM_WIDTH-1:0]        accum_out,
  output logic                         accum_busy,
  output logic                         accum_done,
  output logic                         accum_overflow
);
  localparam int RW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  vpe_accum_state_t state, state_d;
  logic [PSUM_WIDTH-1:0]  row_buf [DEPTH];
  logic [AW-1:0]          row_ptr, rows_m1;
  logic [KTILE_WIDTH-1:0] k_cnt, k_m1;
  logic [RW-1:0]          rows_c;
  logic                   start_ok, accept, last_row, final_in, add_ovf;
  logic [PSUM_WIDTH-1:0]  sum, val;
  assign start_ok = (state == IDLE) && accum_start;
  assign accept   = (state == ACCUM) && accum_in_valid;
  assign last_row = row_ptr == rows_m1;
  assign final_in = accept && (k_cnt == k_m1);
  assign rows_c   = (tile_rows == '0 || tile_rows > RW'(DEPTH)) ? RW'(DEPTH) : tile_rows;
  // Flop-array read is combinational, so a rows==1 back-to-back RMW already
  // sees the previous cycle's write.
  vpe_sat_adder #(.WIDTH(PSUM_WIDTH)) u_add (
    .a  (row_buf[row_ptr]),
    .b  (accum_in),
    .sum(sum),
    .ovf(add_ovf)
  );
  // Pass 0 overwrites so stale buffer contents never contribute.
  assign val = (k_cnt == '0) ? accum_in : sum;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else      state <= state_d;
  always_comb
    state_d = (state == IDLE) ? (accum_start ? ACCUM : IDLE)
                              : ((final_in && last_row) ? IDLE : ACCUM);
  always_comb
    accum_busy = state == ACCUM;
  always_ff @(posedge clk)
    if (!rst) begin
      row_ptr         <= '0;
      k_cnt           <= '0;
      rows_m1         <= '0;
      k_m1            <= '0;
      accum_out_valid <= 1'b0;
      accum_out       <= '0;
      accum_done      <= 1'b0;
      accum_overflow  <= 1'b0;
    end else begin
      accum_out_valid <= final_in;
      accum_done      <= final_in && last_row;
      if (final_in) accum_out <= val;
      if (start_ok) begin
        row_ptr        <= '0;
        k_cnt          <= '0;
        rows_m1        <= AW'(rows_c - 1'b1);
        k_m1           <= (num_k_tiles == '0) ? '0 : num_k_tiles - 1'b1;
        accum_overflow <= 1'b0;
      end else if (accept) begin
        row_ptr <= last_row ? '0 : row_ptr + 1'b1;
        if (last_row) k_cnt <= k_cnt + 1'b1;
        if (k_cnt != '0 && add_ovf) accum_overflow <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (rst && accept) row_buf[row_ptr] <= val;
endmodule
